// File: rtl/seg_scan_ctrl_pkg.sv
// Shared display/time-keeping definitions: BCD digit type and the blank segment pattern.
package seg_scan_ctrl_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  typedef logic [3:0] bcd_t;
endpackage

// File: rtl/seg_scan_ctrl_bcd7seg.sv
// BCD to active-low seven-segment decoder, {g,f,e,d,c,b,a}; non-decimal codes go dark.
module seg_scan_ctrl_bcd7seg
  import seg_scan_ctrl_pkg::*;
(
  input  bcd_t       digit,
  output logic [6:0] seg
);
  always_comb begin
    case (digit)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/seg_scan_ctrl.sv
// Seven-segment scan controller: frame-coherent shadow digits, anode sequencing with guard
// time, leading-zero blanking and per-digit blink, all through one shared decoder.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int NDIG         = 8,
  parameter int SCAN_DIV     = 50000,
  parameter int GUARD        = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4*NDIG-1:0] bcd_in,
  input  logic [NDIG-1:0]   dp_in,
  input  logic              load,
  input  logic              lz_en,
  input  logic [NDIG-1:0]   blink_mask,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [NDIG-1:0]   an,
  output logic              frame_start
);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PW-1:0]   pc;
  logic [IW-1:0]   idx;
  logic [FW-1:0]   fcnt;
  logic            bph;
  logic            pend_v;
  bcd_t [NDIG-1:0] pend, shadow, nxt_sh;
  logic [NDIG-1:0] pend_dp, sh_dp, nxt_dp, lzm, lzm_n;
  logic            slot_end, fb, commit, blank, allz;
  logic [6:0]      dec_seg;

  assign slot_end = (pc == PW'(SCAN_DIV - 1));
  assign fb       = slot_end && (idx == IW'(NDIG - 1));
  assign commit   = fb && (load || pend_v);

  // A load landing on the frame boundary bypasses the pending register.
  assign nxt_sh = load ? bcd_in : pend;
  assign nxt_dp = load ? dp_in : pend_dp;

  always_comb begin
    lzm_n = '0;
    allz  = 1'b1;
    for (int i = NDIG - 1; i > 0; i--) begin
      allz     = allz & (nxt_sh[i] == 4'h0);
      lzm_n[i] = lz_en & allz;
    end
  end

  assign blank = lzm[idx] | (blink_mask[idx] & bph);

  seg_scan_ctrl_bcd7seg u_dec (
    .digit (shadow[idx]),
    .seg   (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= '0;
      idx         <= '0;
      fcnt        <= '0;
      bph         <= 1'b0;
      pend_v      <= 1'b0;
      pend        <= '0;
      pend_dp     <= '0;
      shadow      <= '0;
      sh_dp       <= '0;
      lzm         <= '0;
      seg         <= SEG_BLANK;
      dp          <= 1'b1;
      an          <= '1;
      frame_start <= 1'b0;
    end else begin
      pc <= slot_end ? '0 : pc + 1'b1;
      if (slot_end)
        idx <= (idx == IW'(NDIG - 1)) ? '0 : idx + 1'b1;

      if (load && !fb) begin
        pend    <= bcd_in;
        pend_dp <= dp_in;
        pend_v  <= 1'b1;
      end else if (fb) begin
        pend_v  <= 1'b0;
      end

      if (commit) begin
        shadow <= nxt_sh;
        sh_dp  <= nxt_dp;
        lzm    <= lzm_n;
      end

      if (fb) begin
        if (fcnt == FW'(BLINK_FRAMES - 1)) begin
          fcnt <= '0;
          bph  <= ~bph;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end

      seg         <= blank ? SEG_BLANK : dec_seg;
      dp          <= blank | ~sh_dp[idx];
      an          <= (pc < PW'(GUARD)) ? '1 : ~(NDIG'(1) << idx);
      frame_start <= (pc == '0) && (idx == '0);
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a cycle-count reference model queues the expected
// pin state for every edge, a negedge monitor pops and compares.
module tb_seg_scan_ctrl;
  localparam int NDIG = 4, SCAN_DIV = 8, GUARD = 2, BLINK_FRAMES = 2;
  localparam int FR = NDIG * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst, load, lz_en;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in, blink_mask;
  logic [6:0]  seg;
  logic        dp, frame_start;
  logic [3:0]  an;

  seg_scan_ctrl #(.NDIG(NDIG), .SCAN_DIV(SCAN_DIV), .GUARD(GUARD), .BLINK_FRAMES(BLINK_FRAMES)) dut (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .dp_in(dp_in), .load(load), .lz_en(lz_en),
    .blink_mask(blink_mask), .seg(seg), .dp(dp), .an(an), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       fs;
  } exp_t;

  exp_t q[$];
  int   checks = 0, failures = 0;

  // Model state: k = cycles since reset release; displayed value is fixed per frame.
  int          k = 0;
  logic [15:0] cur_val = 0, pend_val = 0;
  logic [3:0]  cur_dp = 0, pend_dp = 0;
  logic        cur_lz = 0, pend_have = 0;
  logic [6:0]  segs [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  always @(posedge clk) begin
    exp_t e;
    int   pcm, idm, hi, d;
    logic bphm, blk;
    if (rst) begin
      e = '{seg: 7'h7F, dp: 1'b1, an: 4'hF, fs: 1'b0};
      q.push_back(e);
      k = 0; cur_val = 0; cur_dp = 0; cur_lz = 0; pend_have = 0;
    end else begin
      pcm  = k % SCAN_DIV;
      idm  = (k / SCAN_DIV) % NDIG;
      bphm = ((k / FR) / BLINK_FRAMES) % 2 == 1;
      hi = 0;
      for (int i = 0; i < NDIG; i++)
        if (((cur_val >> (4 * i)) & 16'hF) != 0) hi = i;
      blk  = (cur_lz && idm > hi) || (blink_mask[idm] && bphm);
      d    = int'((cur_val >> (4 * idm)) & 16'hF);
      e.seg = blk ? 7'h7F : (d < 10 ? segs[d] : 7'h7F);
      e.dp  = blk ? 1'b1 : !cur_dp[idm];
      e.an  = (pcm < GUARD) ? 4'hF : ~(4'b0001 << idm);
      e.fs  = (k % FR) == 0;
      q.push_back(e);
      if (load) begin
        pend_have = 1; pend_val = bcd_in; pend_dp = dp_in;
      end
      if ((k % FR) == FR - 1 && pend_have) begin
        cur_val = pend_val; cur_dp = pend_dp; cur_lz = lz_en; pend_have = 0;
      end
      k++;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({seg, dp, an, frame_start} !== e) begin
        failures++;
        $display("FAIL scan_out t=%0t got seg=%h dp=%b an=%b fs=%b want seg=%h dp=%b an=%b fs=%b",
                 $time, seg, dp, an, frame_start, e.seg, e.dp, e.an, e.fs);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    bcd_in = v; dp_in = d; load = 1'b1;
    cyc(1);
    load = 1'b0;
  endtask

  task automatic wait_k(input int m);
    int n = 0;
    while ((k % FR) != m && n < 4 * FR) begin
      cyc(1);
      n++;
    end
    if ((k % FR) != m) begin
      checks++; failures++;
      $display("FAIL wait_slot got pos=%0d want pos=%0d", k % FR, m);
    end
  endtask

  task automatic chk_pend(input logic want, input string nm);
    checks++;
    if (dut.pend_v !== want) begin
      failures++;
      $display("FAIL %s got pend_v=%b want %b", nm, dut.pend_v, want);
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; lz_en = 1'b0; bcd_in = '0; dp_in = '0; blink_mask = '0;
    cyc(3);
    rst = 1'b0;
    cyc(70);
    wait_k(10);
    do_load(16'h1234, 4'b0010);
    chk_pend(1'b1, "pend_after_load");
    cyc(70);
    lz_en = 1'b1;
    do_load(16'h0007, 4'b0000);
    cyc(70);
    do_load(16'h0000, 4'b0000);
    cyc(70);
    lz_en = 1'b0;
    wait_k(3);
    do_load(16'h1111, 4'b1111);
    cyc(5);
    do_load(16'h2222, 4'b0001);
    cyc(40);
    wait_k(FR - 1);
    do_load(16'h0345, 4'b0100);
    chk_pend(1'b0, "pend_fb_load");
    cyc(40);
    blink_mask = 4'b0001;
    do_load(16'h5678, 4'b0001);
    cyc(6 * FR);
    blink_mask = 4'b0000;
    do_load(16'h000C, 4'b0000);
    cyc(70);
    wait_k(12);
    do_load(16'h9999, 4'b1111);
    cyc(2);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk_pend(1'b0, "pend_after_rst");
    cyc(70);
    rst = 1'b1; bcd_in = 16'h8888; load = 1'b1;
    cyc(1);
    rst = 1'b0; load = 1'b0;
    chk_pend(1'b0, "load_with_rst");
    cyc(40);
    repeat (3000) begin
      load   = ($urandom_range(0, 19) == 0);
      bcd_in = 16'($urandom);
      dp_in  = 4'($urandom);
      if ($urandom_range(0, 99) == 0) lz_en = ~lz_en;
      if ($urandom_range(0, 199) == 0) blink_mask = 4'($urandom);
      if ($urandom_range(0, 9) == 0) bcd_in = bcd_in & 16'h00FF;
      rst = ($urandom_range(0, 599) == 0);
      cyc(1);
    end
    rst = 1'b0; load = 1'b0;
    cyc(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
